factorial_engine: RTL and testbench
===================================

# factorial_engine

Parametrised, multi-cycle factorial unit that succeeds the fixed 4-bit-in/8-bit-out factorial FSM/datapath pair. It computes n! for an N_W-bit operand into an R_W-bit result, using one multiply per clock. It adds a busy/done handshake, a sticky overflow flag and optional saturation. It sits as a self-contained compute block behind any controller that can pulse `start`.

## Interface
- N_W, 4: operand width; n ranges over 0 .. 2^N_W-1.
- R_W, 16: result/accumulator width; R_W >= N_W is required.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a rising edge only while busy=0.
- n_in  in  N_W  operand, captured on the accepting edge.
- busy  out  1  high from the accepting edge until DONE is left.
- done  out  1  one-cycle completion pulse.
- result  out  R_W  n! (or truncated/saturated value); held until the next completion.
- overflow  out  1  true n! did not fit in R_W bits; valid with done, held like result.

## Operation
- States:
  - IDLE: wait for start.
  - MUL: iterate.
  - DONE: signal completion.
  - busy = (state != IDLE).
- IDLE -> MUL when start=1:
  - cnt <= n_in, acc <= 1, ovf <= 0.
  - start in any other state is ignored; no queuing.
- MUL with cnt >= 2:
  - p = acc * cnt, computed at full width R_W+N_W.
  - acc <= p[R_W-1:0] and cnt <= cnt-1.
  - ovf <= ovf | (p[R_W+N_W-1:R_W] != 0).
- MUL with cnt <= 1 -> DONE:
  - result <= acc and overflow <= ovf on the same edge.
  - n=0 and n=1 therefore both yield 1.
- DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- n_in changes after the accepting edge have no effect.
- Reset (async assert, any state):
  - state=IDLE, busy=0, done=0, result=0, overflow=0.
  - An in-flight computation is discarded and no done is issued.
  - First accept is possible on the first rising edge with reset_n=1.

## Timing
- Accepting edge = E0. done is high in the cycle following edge E(max(n,1)).
  - n=5: E0 accept; E1..E4 multiply by 5,4,3,2; E5 -> DONE; done high after E5.
- Back-to-back throughput: one operation per max(n,1)+2 cycles. start may be held high during DONE; it is accepted on the edge that returns to IDLE... not accepted there, because busy=1 on that edge. It is accepted on the following edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- result and overflow change only on the edge that enters DONE.

## Configuration
- FACT_SATURATE_EN defined:
  - When ovf becomes 1, acc is forced to all-ones and held there for the rest of the operation.
  - result = 2^R_W-1 whenever overflow=1.
- FACT_SATURATE_EN undefined:
  - result = n! mod 2^R_W (wrap-around).
  - overflow is still reported.
- Latency and handshake are identical in both builds.

## Test plan
- Default params, n_in=5, start pulsed 1 cycle -> busy=1; done exactly 5 cycles after the accepting edge; result=120, overflow=0; busy=0 the cycle after done.
- n_in=0 and then n_in=1 -> each gives done 1 cycle after accept, result=1, overflow=0.
- n_in=8 -> result=40320 (0x9D80), overflow=0. n_in=9 -> overflow=1, and result depends on the build:
  - with FACT_SATURATE_EN: 0xFFFF.
  - without FACT_SATURATE_EN: 0x8980.
- R_W=8, n_in=5 -> 120, overflow=0. R_W=8, n_in=6 -> overflow=1, and result depends on the build:
  - with FACT_SATURATE_EN: 0xFF.
  - without FACT_SATURATE_EN: 0xD0.
- n_in=7 accepted, then start pulsed with n_in=3 while busy -> second request ignored; single done with result=5040.
- reset_n pulled low 3 cycles into an n_in=9 run -> all outputs 0 immediately and no done pulse. After release, n_in=4 -> result=24.

Source files
------------

// File: rtl/factorial_engine.sv
// factorial_engine
// Multi-cycle n! unit: one multiply per clock, busy/done handshake,
// sticky overflow flag. Optional saturation via macro FACT_SATURATE_EN:
// when defined, the accumulator pins to all-ones once overflow occurs;
// otherwise the result wraps modulo 2^R_W. R_W must be >= N_W.
module factorial_engine #(
    parameter int N_W = 4,
    parameter int R_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N_W-1:0] n_in,
    output logic           busy,
    output logic           done,
    output logic [R_W-1:0] result,
    output logic           overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [N_W-1:0]     r_cnt;
    logic [R_W-1:0]     r_acc;
    logic               r_ovf;
    logic [R_W-1:0]     r_result;
    logic               r_overflow;

    logic [R_W+N_W-1:0] w_product;
    logic               w_prodHigh;
    logic               w_ovfNext;
    logic [R_W-1:0]     w_accNext;
    logic               w_cntAbove1;

    // Full-width product so no carry out of the accumulator is lost.
    assign w_product   = {{N_W{1'b0}}, r_acc} * {{R_W{1'b0}}, r_cnt};
    assign w_prodHigh  = (w_product[R_W+N_W-1:R_W] != '0);
    assign w_ovfNext   = r_ovf | w_prodHigh;
    assign w_cntAbove1 = (r_cnt > N_W'(1));

`ifdef FACT_SATURATE_EN
    // Once overflow is seen, pin the accumulator to all-ones for the rest of the run.
    assign w_accNext = w_ovfNext ? '1 : w_product[R_W-1:0];
`else
    // Keep the low R_W bits, giving n! modulo 2^R_W.
    assign w_accNext = w_product[R_W-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: accept in IDLE, iterate in MUL until cnt <= 1, single-cycle DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_MUL;
                end
            end
            S_MUL: begin
                if (!w_cntAbove1) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: load operand on accept, multiply-and-count in MUL, publish on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= n_in;
                        r_acc <= R_W'(1);
                        r_ovf <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (w_cntAbove1) begin
                        r_acc <= w_accNext;
                        r_cnt <= r_cnt - N_W'(1);
                        r_ovf <= w_ovfNext;
                    end else begin
                        r_result   <= r_acc;
                        r_overflow <= r_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_factorial_engine.sv
// Testbench for factorial_engine: a 16-bit and an 8-bit result instance,
// table-driven operations plus hand-written busy-ignore, back-to-back
// and mid-run reset sequences. Expected values follow FACT_SATURATE_EN.
module tb_factorial_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start16, start8;
    logic [3:0]  n16, n8;
    logic        busy16, done16, ovf16;
    logic        busy8, done8, ovf8;
    logic [15:0] res16;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit sel8;
        int n;
        int expResult;
        int expOvf;
        int expLat;
    } vec_t;

    vec_t vecs[10];

`ifdef FACT_SATURATE_EN
    localparam int EXP_N9_16 = 32'hFFFF;
    localparam int EXP_N6_8  = 32'hFF;
`else
    localparam int EXP_N9_16 = 32'h8980;
    localparam int EXP_N6_8  = 32'hD0;
`endif

    factorial_engine #(.N_W(4), .R_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .n_in(n16),
        .busy(busy16), .done(done16), .result(res16), .overflow(ovf16)
    );

    factorial_engine #(.N_W(4), .R_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .n_in(n8),
        .busy(busy8), .done(done8), .result(res8), .overflow(ovf8)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic int getBusy(input bit sel8);
        return sel8 ? int'(busy8) : int'(busy16);
    endfunction

    function automatic int getDone(input bit sel8);
        return sel8 ? int'(done8) : int'(done16);
    endfunction

    function automatic int getResult(input bit sel8);
        return sel8 ? int'(res8) : int'(res16);
    endfunction

    function automatic int getOvf(input bit sel8);
        return sel8 ? int'(ovf8) : int'(ovf16);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Present a start request with operand n at the next falling edge.
    task automatic applyStimulus(input bit sel8, input int n);
        @(negedge clk);
        if (sel8) begin
            start8 = 1'b1;
            n8     = 4'(n);
        end else begin
            start16 = 1'b1;
            n16     = 4'(n);
        end
    endtask

    // Full operation: accept, measure latency to done, check outputs and return to idle.
    task automatic runOp(input bit sel8, input int n, input int expRes,
                         input int expOvf, input int expLat, input string tag);
        int lat;
        bit got;
        applyStimulus(sel8, n);
        @(posedge clk);
        #1;
        checkOutput({tag, " busy_after_accept"}, getBusy(sel8), 1);
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        n8      = 4'($urandom_range(0, 15));
        n16     = 4'($urandom_range(0, 15));
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (getDone(sel8) == 1) begin
                got = 1'b1;
                lat = k;
            end
        end
        if (!got) begin
            checkOutput({tag, " done_timeout"}, 0, 1);
        end else begin
            checkOutput({tag, " latency"}, lat, expLat);
            checkOutput({tag, " result"}, getResult(sel8), expRes);
            checkOutput({tag, " overflow"}, getOvf(sel8), expOvf);
            @(posedge clk);
            #1;
            checkOutput({tag, " done_one_cycle"}, getDone(sel8), 0);
            checkOutput({tag, " busy_cleared"}, getBusy(sel8), 0);
            @(negedge clk);
            checkOutput({tag, " result_held"}, getResult(sel8), expRes);
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int doneCount;
        int doneIdx[2];
        int capRes;

        vecs[0] = '{1'b0, 5, 120,       0, 5};
        vecs[1] = '{1'b0, 0, 1,         0, 1};
        vecs[2] = '{1'b0, 1, 1,         0, 1};
        vecs[3] = '{1'b0, 8, 40320,     0, 8};
        vecs[4] = '{1'b0, 9, EXP_N9_16, 1, 9};
        vecs[5] = '{1'b0, 3, 6,         0, 3};
        vecs[6] = '{1'b1, 5, 120,       0, 5};
        vecs[7] = '{1'b1, 6, EXP_N6_8,  1, 6};
        vecs[8] = '{1'b1, 0, 1,         0, 1};
        vecs[9] = '{1'b0, 2, 2,         0, 2};

        reset_n = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;
        n16     = '0;
        n8      = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", int'(busy16), 0);
        checkOutput("reset done", int'(done16), 0);
        checkOutput("reset result", int'(res16), 0);
        checkOutput("reset overflow", int'(ovf16), 0);
        checkOutput("reset result8", int'(res8), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].sel8, vecs[i].n, vecs[i].expResult, vecs[i].expOvf,
                  vecs[i].expLat, $sformatf("vec%0d_n%0d_%s", i, vecs[i].n,
                  vecs[i].sel8 ? "r8" : "r16"));
        end

        // Back-to-back with start held: n=2 gives done after E2, re-accept at E4, done after E6.
        applyStimulus(1'b0, 2);
        @(posedge clk);
        doneCount  = 0;
        doneIdx[0] = -1;
        doneIdx[1] = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) checkOutput("b2b busy_idle_gap", int'(busy16), 0);
            if (k == 4) checkOutput("b2b busy_reaccept", int'(busy16), 1);
            if (done16) begin
                if (doneCount < 2) doneIdx[doneCount] = k;
                doneCount++;
            end
            if (k == 5) start16 = 1'b0;
        end
        checkOutput("b2b done_count", doneCount, 2);
        checkOutput("b2b first_done", doneIdx[0], 2);
        checkOutput("b2b second_done", doneIdx[1], 6);
        checkOutput("b2b result", int'(res16), 2);

        // Start while busy is ignored: only the n=7 operation completes.
        applyStimulus(1'b0, 7);
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("ignore busy_during", int'(busy16), 1);
        start16 = 1'b1;
        n16     = 4'd3;
        @(negedge clk);
        start16 = 1'b0;
        doneCount = 0;
        capRes    = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done16) begin
                doneCount++;
                capRes = int'(res16);
            end
        end
        checkOutput("ignore done_count", doneCount, 1);
        checkOutput("ignore result", capRes, 5040);
        checkOutput("ignore overflow", int'(ovf16), 0);
        checkOutput("ignore busy_end", int'(busy16), 0);

        // Reset three cycles into an n=9 run: outputs clear at once, no done follows.
        applyStimulus(1'b0, 9);
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset busy", int'(busy16), 0);
        checkOutput("midreset done", int'(done16), 0);
        checkOutput("midreset result", int'(res16), 0);
        checkOutput("midreset overflow", int'(ovf16), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        doneCount = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done16) doneCount++;
        end
        checkOutput("midreset no_done", doneCount, 0);
        runOp(1'b0, 4, 24, 0, 4, "after_reset_n4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
